// File: rtl/aqed_fc_checker.sv
// A-QED functional-consistency and response-bound checker for an in-order streaming DUT.
// Watches both handshakes and compares the responses of a tagged original and its later duplicate.
//
// state | meaning
// IDLE  | waiting for an accepted input tagged as the original
// ORIG  | original captured, waiting for a matching duplicate input
// DUP   | duplicate captured, waiting for both responses
// DONE  | both responses seen, qed_check valid (terminal)
// ABORT | input counter wrapped before a duplicate arrived (terminal)
module aqed_fc_checker #(
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 16,
    parameter int CNT_W   = 8,
    parameter int DEPTH   = 4,
    parameter int MAX_LAT = 16,
    parameter bit RB_EN   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         out_valid,
    input  logic                         out_ready,
    input  logic [OUT_W-1:0]             out_data,
    input  logic                         exec_orig,
    input  logic                         exec_dup,
    output logic                         orig_issued,
    output logic                         dup_issued,
    output logic                         insert_cond,
    output logic                         delete_cond,
    output logic [$clog2(DEPTH+1)-1:0]   in_flight,
    output logic                         full,
    output logic                         empty,
    output logic                         qed_done,
    output logic                         qed_check,
    output logic                         rb_fail,
    output logic                         proto_err
);

    localparam int FL_W  = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {IDLE, ORIG, DUP, DONE, ABORT} state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]  in_cnt, out_cnt, orig_idx, dup_idx, in_cnt_inc;
    logic [DATA_W-1:0] orig_data;
    logic [OUT_W-1:0]  orig_out, dup_out, orig_out_nx, dup_out_nx;
    logic              orig_out_vld, dup_out_vld;
    logic [LAT_W-1:0]  lat_cnt;

    logic in_fire, out_fire;
    logic orig_cap, dup_cap, wrap, resp_act, orig_resp, dup_resp, go_done;
    logic lat_max;

    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign insert_cond = in_fire;
    assign delete_cond = out_fire;

    assign full  = (in_flight == FL_W'(DEPTH));
    assign empty = (in_flight == '0);

    assign in_cnt_inc = in_cnt + CNT_W'(1);
    assign orig_cap   = (state == IDLE) & in_fire & exec_orig;
    assign dup_cap    = (state == ORIG) & in_fire & exec_dup & (in_data == orig_data);
    // A full lap of the sequence space would make orig_idx ambiguous on the output side
    assign wrap       = (state == ORIG) & in_fire & ~dup_cap & (in_cnt_inc == orig_idx);

    assign resp_act  = (state == ORIG) | (state == DUP);
    assign orig_resp = resp_act & out_fire & (out_cnt == orig_idx) & ~orig_out_vld;
    assign dup_resp  = resp_act & out_fire & dup_issued & (out_cnt == dup_idx) & ~dup_out_vld;
    assign go_done   = (state == DUP) & (orig_out_vld | orig_resp) & (dup_out_vld | dup_resp);

    assign orig_out_nx = orig_resp ? out_data : orig_out;
    assign dup_out_nx  = dup_resp ? out_data : dup_out;

    assign lat_max = (lat_cnt == LAT_W'(MAX_LAT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (orig_cap) state_nx = ORIG;
            ORIG: begin
                if (dup_cap)   state_nx = DUP;
                else if (wrap) state_nx = ABORT;
            end
            DUP:     if (go_done) state_nx = DONE;
            DONE:    state_nx = DONE;
            ABORT:   state_nx = ABORT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_cnt       <= '0;
            out_cnt      <= '0;
            in_flight    <= '0;
            orig_idx     <= '0;
            dup_idx      <= '0;
            orig_data    <= '0;
            orig_out     <= '0;
            dup_out      <= '0;
            orig_out_vld <= 1'b0;
            dup_out_vld  <= 1'b0;
            orig_issued  <= 1'b0;
            dup_issued   <= 1'b0;
            lat_cnt      <= '0;
            qed_done     <= 1'b0;
            qed_check    <= 1'b0;
            rb_fail      <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (in_fire)  in_cnt  <= in_cnt_inc;
            if (out_fire) out_cnt <= out_cnt + CNT_W'(1);

            // Violating events leave the occupancy untouched
            if (in_fire && !out_fire && !full)
                in_flight <= in_flight + FL_W'(1);
            else if (out_fire && !in_fire && !empty)
                in_flight <= in_flight - FL_W'(1);

            if ((out_fire && empty && !in_fire) || (in_fire && full && !out_fire))
                proto_err <= 1'b1;

            if (orig_cap) begin
                orig_data   <= in_data;
                orig_idx    <= in_cnt;
                orig_issued <= 1'b1;
            end
            if (dup_cap) begin
                dup_idx    <= in_cnt;
                dup_issued <= 1'b1;
            end

            if (orig_resp) begin
                orig_out     <= out_data;
                orig_out_vld <= 1'b1;
            end
            if (dup_resp) begin
                dup_out     <= out_data;
                dup_out_vld <= 1'b1;
            end

            if (go_done) begin
                qed_done  <= 1'b1;
                qed_check <= (orig_out_nx == dup_out_nx);
            end

            if (orig_cap)
                lat_cnt <= '0;
            else if (orig_issued && !orig_out_vld && !lat_max)
                lat_cnt <= lat_cnt + LAT_W'(1);

            // A response landing in the saturation cycle is still on time
            if (RB_EN && orig_issued && !orig_out_vld && !orig_resp && lat_max)
                rb_fail <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aqed_fc_checker.sv
// Scoreboard bench for aqed_fc_checker: expected outputs are queued with each stimulus cycle
// and compared after the following clock edge.
module tb_aqed_fc_checker;

    localparam int DEPTH   = 4;
    localparam int MAX_LAT = 4;

    localparam int S_OI = 0, S_DI = 1, S_INS = 2, S_DEL = 3, S_FL = 4, S_FULL = 5,
                   S_EMPTY = 6, S_QD = 7, S_QC = 8, S_RB = 9, S_PE = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready = 1'b0, out_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = '0, out_data = '0;
    logic        exec_orig = 1'b0, exec_dup = 1'b0;
    logic        orig_issued, dup_issued, insert_cond, delete_cond;
    logic [2:0]  in_flight;
    logic        full, empty, qed_done, qed_check, rb_fail, proto_err;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];

    aqed_fc_checker #(
        .DATA_W(16), .OUT_W(16), .CNT_W(8), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT), .RB_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .exec_orig(exec_orig), .exec_dup(exec_dup),
        .orig_issued(orig_issued), .dup_issued(dup_issued),
        .insert_cond(insert_cond), .delete_cond(delete_cond),
        .in_flight(in_flight), .full(full), .empty(empty),
        .qed_done(qed_done), .qed_check(qed_check),
        .rb_fail(rb_fail), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int s);
        case (s)
            S_OI:    return 32'(orig_issued);
            S_DI:    return 32'(dup_issued);
            S_INS:   return 32'(insert_cond);
            S_DEL:   return 32'(delete_cond);
            S_FL:    return 32'(in_flight);
            S_FULL:  return 32'(full);
            S_EMPTY: return 32'(empty);
            S_QD:    return 32'(qed_done);
            S_QC:    return 32'(qed_check);
            S_RB:    return 32'(rb_fail);
            S_PE:    return 32'(proto_err);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic want(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, obs(e.sig), e.exp);
        end
    endtask

    task automatic drv(input logic iv, input logic ir, input logic [15:0] id,
                       input logic ov, input logic orr, input logic [15:0] od,
                       input logic eo, input logic ed);
        in_valid  = iv;
        in_ready  = ir;
        in_data   = id;
        out_valid = ov;
        out_ready = orr;
        out_data  = od;
        exec_orig = eo;
        exec_dup  = ed;
    endtask

    task automatic idle();
        drv(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic want_cleared(input string tag);
        want({tag, "_oi"}, S_OI, 0);
        want({tag, "_di"}, S_DI, 0);
        want({tag, "_fl"}, S_FL, 0);
        want({tag, "_full"}, S_FULL, 0);
        want({tag, "_empty"}, S_EMPTY, 1);
        want({tag, "_qd"}, S_QD, 0);
        want({tag, "_qc"}, S_QC, 0);
        want({tag, "_rb"}, S_RB, 0);
        want({tag, "_pe"}, S_PE, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_match(input string tag, input logic [15:0] dup_resp, input logic exp_check);
        do_reset();
        drv(1, 1, 16'h00AB, 0, 1, 16'h0, 1, 0);
        want({tag, "_oi"}, S_OI, 1);
        want({tag, "_ins"}, S_INS, 1);
        tick();
        drv(1, 1, 16'h1234, 0, 1, 16'h0, 0, 0);
        tick();
        drv(1, 1, 16'h00AB, 0, 1, 16'h0, 0, 1);
        want({tag, "_di"}, S_DI, 1);
        want({tag, "_fl3"}, S_FL, 3);
        tick();
        drv(0, 1, 16'h0, 1, 1, 16'h0056, 0, 0);
        want({tag, "_del"}, S_DEL, 1);
        want({tag, "_qd_a"}, S_QD, 0);
        tick();
        drv(0, 1, 16'h0, 1, 1, 16'h0099, 0, 0);
        want({tag, "_qd_b"}, S_QD, 0);
        tick();
        drv(0, 1, 16'h0, 1, 1, dup_resp, 0, 0);
        want({tag, "_qd"}, S_QD, 1);
        want({tag, "_qc"}, S_QC, 32'(exp_check));
        want({tag, "_empty"}, S_EMPTY, 1);
        want({tag, "_rb"}, S_RB, 0);
        tick();
        idle();
        want({tag, "_qd_hold"}, S_QD, 1);
        want({tag, "_qc_hold"}, S_QC, 32'(exp_check));
        tick();
    endtask

    initial begin
        logic iv, ir, ov, orr;

        // Reset held low under random stimulus
        for (int i = 0; i < 2; i++) begin
            iv  = 1'($urandom_range(0, 1));
            ir  = 1'($urandom_range(0, 1));
            ov  = 1'($urandom_range(0, 1));
            orr = 1'($urandom_range(0, 1));
            drv(iv, ir, 16'($urandom), ov, orr, 16'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            want_cleared("rst");
            want("rst_ins", S_INS, 32'(iv & ir));
            want("rst_del", S_DEL, 32'(ov & orr));
            tick();
        end
        reset = 1'b1;

        run_match("match", 16'h0056, 1'b1);
        run_match("mism", 16'h0057, 1'b0);

        // Late original response
        do_reset();
        drv(1, 1, 16'h0042, 0, 1, 16'h0, 1, 0);
        tick();
        idle();
        for (int c = 1; c <= 6; c++) begin
            want($sformatf("late_rb_c%0d", c), S_RB, (c >= 5) ? 1 : 0);
            tick();
        end
        drv(0, 1, 16'h0, 1, 1, 16'h0077, 0, 0);
        want("late_rb_sticky", S_RB, 1);
        tick();

        // Response landing exactly at the bound
        do_reset();
        drv(1, 1, 16'h0042, 0, 1, 16'h0, 1, 0);
        tick();
        idle();
        for (int c = 1; c <= 4; c++) tick();
        drv(0, 1, 16'h0, 1, 1, 16'h0077, 0, 0);
        want("edge_rb", S_RB, 0);
        tick();
        idle();
        want("edge_rb_after", S_RB, 0);
        tick();

        // Capacity and protocol errors
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drv(1, 1, 16'(k), 0, 1, 16'h0, 0, 0);
            want($sformatf("cap_fl%0d", k), S_FL, k);
            want($sformatf("cap_full%0d", k), S_FULL, (k == 4) ? 1 : 0);
            want($sformatf("cap_pe%0d", k), S_PE, 0);
            tick();
        end
        drv(1, 1, 16'h5, 0, 1, 16'h0, 0, 0);
        want("ovf_pe", S_PE, 1);
        want("ovf_fl", S_FL, 4);
        tick();
        drv(1, 1, 16'h6, 1, 1, 16'h0, 0, 0);
        want("both_fl", S_FL, 4);
        want("both_pe", S_PE, 1);
        tick();
        drv(0, 1, 16'h0, 1, 1, 16'h0, 0, 0);
        want("drain_fl", S_FL, 3);
        want("drain_full", S_FULL, 0);
        tick();

        do_reset();
        drv(0, 1, 16'h0, 1, 1, 16'h0, 0, 0);
        want("udf_pe", S_PE, 1);
        want("udf_fl", S_FL, 0);
        want("udf_empty", S_EMPTY, 1);
        tick();

        do_reset();
        drv(1, 1, 16'h0, 1, 1, 16'h0, 0, 0);
        want("pass_pe", S_PE, 0);
        want("pass_fl", S_FL, 0);
        tick();

        // Reset while in DUP, then a mismatched duplicate
        do_reset();
        drv(1, 1, 16'h00AB, 0, 1, 16'h0, 1, 0);
        tick();
        drv(1, 1, 16'h00AB, 0, 1, 16'h0, 0, 1);
        want("rdup_di", S_DI, 1);
        tick();
        reset = 1'b0;
        idle();
        want_cleared("rdup_rst");
        tick();
        reset = 1'b1;
        drv(1, 1, 16'h00CD, 0, 1, 16'h0, 1, 0);
        want("rdup_oi", S_OI, 1);
        want("rdup_di0", S_DI, 0);
        tick();
        drv(1, 1, 16'h00CE, 0, 1, 16'h0, 0, 1);
        want("rdup_mism_di", S_DI, 0);
        want("rdup_mism_fl", S_FL, 2);
        tick();
        drv(1, 1, 16'h00CD, 0, 1, 16'h0, 0, 1);
        want("rdup_match_di", S_DI, 1);
        tick();

        // Input counter wraps to orig_idx before any duplicate: abort
        do_reset();
        drv(1, 1, 16'h00AB, 0, 1, 16'h0, 1, 0);
        tick();
        drv(1, 1, 16'h0011, 1, 1, 16'h0033, 0, 0);
        for (int k = 0; k < 255; k++) tick();
        drv(1, 1, 16'h00AB, 0, 1, 16'h0, 0, 1);
        want("abort_di", S_DI, 0);
        want("abort_oi", S_OI, 1);
        want("abort_fl", S_FL, 2);
        tick();
        idle();
        want("abort_qd", S_QD, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
